// File: rtl/cn_sched.sv
// Column scheduler for the serial CN bank: clears CN queues, sweeps V2C columns each iteration,
// delays the read strobe/column to the CN units, counts iterations and applies early termination.
module cn_sched #(
  parameter int unsigned COL_NUM     = 72,
  parameter int unsigned COL_CNT_WID = 7,
  parameter int unsigned ITER_WID    = 5,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [ITER_WID-1:0]    i_max_iter,
  input  logic                   i_hold,
  input  logic                   i_synd_ok,
  output logic                   o_cn_init,
  output logic                   o_rd_en,
  output logic [COL_CNT_WID-1:0] o_rd_col,
  output logic                   o_cn_vld,
  output logic [COL_CNT_WID-1:0] o_cn_col_cnt,
  output logic [ITER_WID-1:0]    o_iter,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_success
);

  localparam int unsigned DrainWid = $clog2(RD_LAT + 2);
  localparam logic [COL_CNT_WID-1:0] ColLast   = COL_CNT_WID'(COL_NUM - 1);
  localparam logic [DrainWid-1:0]    DrainLast = DrainWid'(RD_LAT);

  typedef enum logic [2:0] {StIdle, StInit, StRun, StDrain, StCheck, StDone} state_e;

  state_e                  state_q, state_d;
  logic [COL_CNT_WID-1:0]  col_q;
  logic [ITER_WID-1:0]     iter_q;
  logic [ITER_WID-1:0]     max_iter_q;
  logic                    success_q;
  logic [DrainWid-1:0]     drain_q;
  logic [RD_LAT-1:0]       dly_vld_q;
  logic [COL_CNT_WID-1:0]  dly_col_q [RD_LAT];
  logic                    start_acc;
  logic                    issue;
  logic                    last_iter;

  assign start_acc = (state_q == StIdle) && i_start;
  assign issue     = (state_q == StRun) && !i_hold;
  assign last_iter = ((iter_q + ITER_WID'(1)) == max_iter_q);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (i_start) state_d = StInit;
      StInit:  state_d = StRun;
      StRun:   if (!i_hold && (col_q == ColLast)) state_d = StDrain;
      StDrain: if (drain_q == DrainLast) state_d = StCheck;
      StCheck: state_d = (i_synd_ok || last_iter) ? StDone : StRun;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    o_cn_init = (state_q == StInit);
    o_rd_en   = issue;
    o_busy    = (state_q == StInit) || (state_q == StRun) || (state_q == StDrain) ||
                (state_q == StCheck);
    o_done    = (state_q == StDone);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q      <= '0;
      iter_q     <= '0;
      max_iter_q <= '0;
      success_q  <= 1'b0;
      drain_q    <= '0;
    end else begin
      drain_q <= (state_q == StDrain) ? drain_q + DrainWid'(1) : '0;
      if (start_acc) begin
        iter_q     <= '0;
        max_iter_q <= (i_max_iter == '0) ? ITER_WID'(1) : i_max_iter;
        success_q  <= 1'b0;
      end
      if (state_q == StInit) begin
        col_q <= '0;
      end else if (issue && (col_q != ColLast)) begin
        col_q <= col_q + COL_CNT_WID'(1);
      end else if (state_q == StCheck && !i_synd_ok && !last_iter) begin
        col_q  <= '0;
        iter_q <= iter_q + ITER_WID'(1);
      end
      if (state_q == StCheck && i_synd_ok) begin
        success_q <= 1'b1;
      end
    end
  end

  // Read-latency match; runs every cycle so stall holes reach the CN units intact
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dly_vld_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        dly_col_q[i] <= '0;
      end
    end else begin
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
        dly_vld_q[i] <= dly_vld_q[i-1];
        dly_col_q[i] <= dly_col_q[i-1];
      end
      dly_vld_q[0] <= o_rd_en;
      dly_col_q[0] <= o_rd_col;
    end
  end

  assign o_rd_col     = col_q;
  assign o_cn_vld     = dly_vld_q[RD_LAT-1];
  assign o_cn_col_cnt = dly_col_q[RD_LAT-1];
  assign o_iter       = iter_q;
  assign o_success    = success_q;

endmodule
